// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, limits and types for the writeback port arbiter slice.
package all_pkgs;

  localparam int unsigned WIDTH          = 32;
  localparam int unsigned MDU_FIFO_DEPTH = 2;
  localparam int unsigned STARVE_LIMIT   = 4;

  typedef enum logic {
    NORMAL,
    FORCE
  } arb_state_t;

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Small result buffer for MDU writebacks; occupancy is fully registered.
module wb_result_fifo
  import all_pkgs::*;
#(
  parameter int unsigned DEPTH = MDU_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= inc_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline and buffered MDU
// results, with starvation forcing and a pending-destination scoreboard.
module wb_port_arbiter
  import all_pkgs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_wr_en,
  input  logic [4:0]       pipe_rd,
  input  logic [WIDTH-1:0] pipe_data,
  input  logic             mdu_valid,
  input  logic [4:0]       mdu_rd,
  input  logic [WIDTH-1:0] mdu_data,
  output logic             mdu_ready,
  input  logic             mdu_issue,
  input  logic [4:0]       mdu_issue_rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_wr_en,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_wr_data,
  output logic             stall_pipe
);

  arb_state_t  state, state_next;
  logic [2:0]  starve_cnt, starve_next;
  logic [31:0] busy, busy_next;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        pipe_valid;
  wb_entry_t   head;

  assign pipe_valid = pipe_wr_en && (pipe_rd != '0);
  assign mdu_ready  = rst_n && !fifo_full;
  // Results targeting x0 are accepted but never enqueued.
  assign fifo_push  = mdu_valid && mdu_ready && (mdu_rd != '0);

  wb_result_fifo #(.DEPTH(MDU_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ('{rd: mdu_rd, data: mdu_data}),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    fifo_pop    = 1'b0;
    stall_pipe  = 1'b0;
    rf_wr_en    = 1'b0;
    rf_rd       = '0;
    rf_wr_data  = '0;
    if (rst_n) begin
      case (state)
        FORCE: begin
          stall_pipe  = 1'b1;
          state_next  = NORMAL;
          starve_next = '0;
          fifo_pop    = !fifo_empty;
        end
        default: begin
          if (pipe_valid) begin
            rf_wr_en    = 1'b1;
            rf_rd       = pipe_rd;
            rf_wr_data  = pipe_data;
            starve_next = fifo_empty ? '0 : starve_cnt + 3'd1;
          end else begin
            fifo_pop    = !fifo_empty;
            starve_next = '0;
          end
          if (starve_next == 3'(STARVE_LIMIT)) state_next = FORCE;
        end
      endcase
      if (fifo_pop) begin
        rf_wr_en   = 1'b1;
        rf_rd      = head.rd;
        rf_wr_data = head.data;
      end
    end
  end

  // Clear first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (fifo_pop) busy_next[head.rd] = 1'b0;
    if (mdu_issue) busy_next[mdu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      busy       <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios followed by random traffic, checked against a queue model.
module tb_wb_port_arbiter;
  import all_pkgs::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pipe_wr_en;
  logic [4:0]       pipe_rd;
  logic [WIDTH-1:0] pipe_data;
  logic             mdu_valid;
  logic [4:0]       mdu_rd;
  logic [WIDTH-1:0] mdu_data;
  logic             mdu_ready;
  logic             mdu_issue;
  logic [4:0]       mdu_issue_rd;
  logic [4:0]       rs1, rs2;
  logic             rs1_busy, rs2_busy;
  logic             rf_wr_en;
  logic [4:0]       rf_rd;
  logic [WIDTH-1:0] rf_wr_data;
  logic             stall_pipe;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .mdu_issue    (mdu_issue),
    .mdu_issue_rd (mdu_issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rf_wr_en     (rf_wr_en),
    .rf_rd        (rf_rd),
    .rf_wr_data   (rf_wr_data),
    .stall_pipe   (stall_pipe)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  // Reference model: pending results in arrival order, pending destinations,
  // count of consecutive starved cycles and a one-shot forced-drain flag.
  logic [4:0]       q_rd   [$];
  logic [WIDTH-1:0] q_data [$];
  logic [31:0]      m_busy = '0;
  int               m_starve = 0;
  bit               m_force = 1'b0;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe_wr_en = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
  endtask

  // One clock: compare mid-cycle, then advance the model at the edge.
  task automatic step();
    bit had, ready, from_q, pipe_won, wr;
    logic [4:0] erd;
    logic [WIDTH-1:0] edata;
    @(negedge clk);
    had = (q_rd.size() > 0);
    ready = rst_n && (q_rd.size() < MDU_FIFO_DEPTH);
    from_q = 0; pipe_won = 0; wr = 0; erd = 0; edata = 0;
    if (rst_n) begin
      if (m_force) from_q = had;
      else if (pipe_wr_en && pipe_rd != 0) begin
        pipe_won = 1; wr = 1; erd = pipe_rd; edata = pipe_data;
      end else from_q = had;
      if (from_q) begin wr = 1; erd = q_rd[0]; edata = q_data[0]; end
    end
    chk("rf_wr_en", rf_wr_en, wr);
    chk("rf_rd", rf_rd, erd);
    chk("rf_wr_data", rf_wr_data, edata);
    chk("stall_pipe", stall_pipe, rst_n && m_force);
    chk("mdu_ready", mdu_ready, ready);
    chk("rs1_busy", rs1_busy, m_busy[rs1]);
    chk("rs2_busy", rs2_busy, m_busy[rs2]);
    @(posedge clk);
    if (!rst_n) begin
      q_rd.delete(); q_data.delete();
      m_busy = '0; m_starve = 0; m_force = 0;
    end else begin
      if (from_q) begin
        m_busy[q_rd[0]] = 1'b0;
        void'(q_rd.pop_front()); void'(q_data.pop_front());
      end
      if (mdu_issue && mdu_issue_rd != 0) m_busy[mdu_issue_rd] = 1'b1;
      if (mdu_valid && ready && mdu_rd != 0) begin
        q_rd.push_back(mdu_rd); q_data.push_back(mdu_data);
      end
      if (m_force) begin m_force = 0; m_starve = 0; end
      else if (!had || from_q) m_starve = 0;
      else if (pipe_won) begin
        m_starve++;
        if (m_starve == STARVE_LIMIT) m_force = 1;
      end
    end
    #1;
  endtask

  initial begin
    idle(); rs1 = 0; rs2 = 0;
    rst_n = 0;
    @(posedge clk); #1;
    step(); step();
    rst_n = 1;
    step(); step();

    // Same-cycle pipeline and MDU: pipeline first, buffered result next cycle.
    pipe_wr_en = 1; pipe_rd = 5; pipe_data = 'hAA;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 'hBB;
    step();
    idle();
    step(); step();

    // Starvation: one buffered entry behind continuous pipeline writes.
    mdu_valid = 1; mdu_rd = 3; mdu_data = 'h33;
    for (int i = 0; i < 8; i++) begin
      pipe_wr_en = 1; pipe_rd = 5'(1 + i % 4); pipe_data = WIDTH'(i + 'h100);
      step();
      mdu_valid = 0;
    end
    idle(); step();

    // Fill the buffer, hold a third result, then drain.
    pipe_wr_en = 1; pipe_rd = 2; pipe_data = 'h22;
    mdu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mdu_rd = 5'(10 + i); mdu_data = WIDTH'('hC0 + i);
      step();
    end
    pipe_wr_en = 0;
    for (int i = 0; i < 3; i++) step();
    idle();
    for (int i = 0; i < 3; i++) step();

    // Scoreboard: issue x9, clear on its writeback, re-issue on writeback.
    rs1 = 9; rs2 = 0;
    mdu_issue = 1; mdu_issue_rd = 9;
    step();
    idle(); step();
    mdu_valid = 1; mdu_rd = 9; mdu_data = 'h99; step();
    mdu_valid = 0; mdu_issue = 1; mdu_issue_rd = 9; step();
    idle(); step();
    mdu_valid = 1; mdu_rd = 9; mdu_data = 'h9A; step();
    idle(); step(); step();

    // Pipeline request to x0 does not take the port.
    pipe_wr_en = 1; pipe_rd = 1; pipe_data = 'h11;
    mdu_valid = 1; mdu_rd = 4; mdu_data = 'h44;
    mdu_issue = 1; mdu_issue_rd = 0;
    step();
    idle(); pipe_wr_en = 1; pipe_rd = 0; pipe_data = 'hFF;
    step();
    idle(); step();

    // Reset while the forced drain cycle is active.
    mdu_valid = 1; mdu_rd = 6; mdu_data = 'h66;
    pipe_wr_en = 1; pipe_rd = 8; pipe_data = 'h88;
    for (int i = 0; i < 20 && !m_force; i++) begin
      step();
      mdu_valid = 0;
    end
    chk("force_reached", m_force, 1'b1);
    rst_n = 0; step();
    rst_n = 1; idle(); step(); step();

    // Random traffic with occasional reset.
    for (int i = 0; i < 800; i++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      pipe_wr_en   = ($urandom_range(0, 3) != 0);
      pipe_rd      = 5'($urandom_range(0, 7));
      pipe_data    = WIDTH'($urandom);
      mdu_valid    = $urandom_range(0, 1) != 0;
      mdu_rd       = 5'($urandom_range(0, 7));
      mdu_data     = WIDTH'($urandom);
      mdu_issue    = $urandom_range(0, 2) == 0;
      mdu_issue_rd = 5'($urandom_range(0, 7));
      rs1          = 5'($urandom_range(0, 7));
      rs2          = 5'($urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
